// File: rtl/mem_req_pkg.sv
// Shared types for the memory-controller request master: FSM states, command record, rw encodings.
// Command fields are sized from the package dimensions, so instances must keep R/C/DW at these values.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int unsigned CMD_R  = 4;
  localparam int unsigned CMD_C  = 4;
  localparam int unsigned CMD_DW = 8;
  localparam int unsigned CMD_AW = $clog2(CMD_R * CMD_C);

  typedef struct packed {
    logic              rw;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_req_master_if.sv
// Upstream command/response, memory-controller and status signals of mem_req_master.
interface mem_req_master_if #(
  parameter int unsigned R  = 4,
  parameter int unsigned C  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
);
  localparam int unsigned AW = $clog2(R * C);
  localparam int unsigned CW = $clog2(N) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_rw;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          mc_cs;
  logic          mc_req;
  logic          mc_rw;
  logic [AW-1:0] mc_addr;
  logic          mc_valid;
  logic [DW-1:0] mc_wdata;
  logic          mc_ready;
  logic [DW-1:0] mc_rdata;

  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  rsp_ready, mc_ready, mc_rdata,
    output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err,
    output mc_cs, mc_req, mc_rw, mc_addr, mc_valid, mc_wdata,
    output busy, fifo_count
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output rsp_ready, mc_ready, mc_rdata,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err,
    input  mc_cs, mc_req, mc_rw, mc_addr, mc_valid, mc_wdata,
    input  busy, fifo_count
  );

endinterface

// File: rtl/mem_req_master_fifo.sv
// Synchronous show-ahead FIFO; power-of-2 depth, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [W-1:0]         i_wdata,
  input  logic                 i_pop,
  output logic [W-1:0]         o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [$clog2(N):0]   o_count
);
  localparam int unsigned PW = $clog2(N);

  logic [W-1:0]  r_mem [N];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Push is gated on full alone, so a same-cycle pop never frees a slot early.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == (PW+1)'(N));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_master.sv
// Memory-controller request initiator: queues upstream commands, issues them one at a time
// to the controller, and returns one response (read data or timeout error) per command.
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int unsigned R   = CMD_R,
  parameter int unsigned C   = CMD_C,
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = CMD_DW,
  parameter int unsigned TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_master_if.master bus
);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned TW = $clog2(TMO);

  cmd_t          w_in;
  cmd_t          w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  state_t        r_state;
  cmd_t          r_hold;
  logic [TW-1:0] r_tmo;
  logic          r_mc_cs;
  logic          r_rsp_valid;
  logic          r_rsp_rw;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;

  assign w_in   = '{rw: bus.cmd_rw, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign w_push = bus.cmd_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty;

  sync_fifo #(
    .W ($bits(cmd_t)),
    .N (N)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Holding register is cleared outside REQ, so mc_* read straight from it stay 0 there.
  assign bus.mc_cs    = r_mc_cs;
  assign bus.mc_req   = r_mc_cs;
  assign bus.mc_rw    = r_hold.rw;
  assign bus.mc_addr  = r_hold.addr;
  assign bus.mc_wdata = r_hold.wdata;
  assign bus.mc_valid = r_hold.rw;

  assign bus.cmd_ready  = !w_full;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rw     = r_rsp_rw;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state != IDLE) || !w_empty;
  assign bus.fifo_count = w_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_tmo       <= '0;
      r_mc_cs     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_hold  <= w_head;
            r_mc_cs <= 1'b1;
            r_tmo   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          r_tmo <= r_tmo + 1'b1;
          // First REQ cycle may see a stale ready left over from the previous command.
          if ((r_tmo != '0) && bus.mc_ready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rw    <= r_hold.rw;
            r_rsp_rdata <= (r_hold.rw == RW_WRITE) ? '0 : bus.mc_rdata;
            r_rsp_err   <= 1'b0;
            r_hold      <= '0;
            r_mc_cs     <= 1'b0;
            r_state     <= RESP;
          end else if (r_tmo == TW'(TMO - 1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rw    <= r_hold.rw;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_hold      <= '0;
            r_mc_cs     <= 1'b0;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rw    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a registered-ready controller model.
module tb_mem_req_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   ctrl_dead = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] mc_mem [16];

  mem_req_master_if #(.R(4), .C(4), .N(4), .DW(8)) bus ();

  mem_req_master #(.R(4), .C(4), .N(4), .DW(8), .TMO(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Controller: ready registered one cycle after cs/req, rdata looked up from its memory.
  always @(posedge clk) begin
    if (rst) begin
      bus.mc_ready <= 1'b0;
      bus.mc_rdata <= 8'h00;
      for (int a = 0; a < 16; a++) mc_mem[a] <= 8'(8'h10 + a);
      mc_mem[0]  <= 8'h5A;
      mc_mem[6]  <= 8'hA5;
      mc_mem[9]  <= 8'h77;
      mc_mem[15] <= 8'hC3;
    end else begin
      bus.mc_ready <= bus.mc_cs && bus.mc_req && !ctrl_dead;
      bus.mc_rdata <= mc_mem[bus.mc_addr];
      if (bus.mc_cs && bus.mc_valid) mc_mem[bus.mc_addr] <= bus.mc_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [3:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic rw, input logic [7:0] rd, input logic err);
    int unsigned n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, bus.rsp_valid, 1);
    chk({tag, "_rw"}, bus.rsp_rw, rw);
    chk({tag, "_rdata"}, bus.rsp_rdata, rd);
    chk({tag, "_err"}, bus.rsp_err, err);
    @(negedge clk);
  endtask

  initial begin
    int unsigned n;
    int unsigned cs_n;
    int unsigned gap;
    bit          seen_hi;
    bit          in_gap;
    bit          done;
    bit          any_rsp;
    bit          cs_hist [12];
    logic [7:0]  rq [$];

    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mc_cs", bus.mc_cs, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read of addr 6 (row 1, col 2), cycle-exact latency
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 4'd6; bus.cmd_wdata = '0;
    chk("rd_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("rd_count_t1", bus.fifo_count, 1);
    chk("rd_cs_t1", bus.mc_cs, 0);
    @(negedge clk);
    chk("rd_cs_t2", bus.mc_cs, 1);
    chk("rd_req_t2", bus.mc_req, 1);
    chk("rd_addr_t2", bus.mc_addr, 6);
    chk("rd_row", bus.mc_addr[3:2], 1);
    chk("rd_col", bus.mc_addr[1:0], 2);
    chk("rd_mcrw", bus.mc_rw, 0);
    chk("rd_mcvalid", bus.mc_valid, 0);
    @(negedge clk);
    chk("rd_cs_t3", bus.mc_cs, 1);
    chk("rd_rspv_t3", bus.rsp_valid, 0);
    @(negedge clk);
    chk("rd_rspv_t4", bus.rsp_valid, 1);
    chk("rd_rdata_t4", bus.rsp_rdata, 8'hA5);
    chk("rd_err_t4", bus.rsp_err, 0);
    chk("rd_rw_t4", bus.rsp_rw, 0);
    chk("rd_cs_t4", bus.mc_cs, 0);
    @(negedge clk);
    chk("rd_rspv_t5", bus.rsp_valid, 0);
    chk("rd_busy_t5", bus.busy, 0);

    // Single write of 3C to addr 9
    push(1'b1, 4'd9, 8'h3C);
    @(negedge clk);
    chk("wr_cs", bus.mc_cs, 1);
    chk("wr_mcvalid", bus.mc_valid, 1);
    chk("wr_mcwdata", bus.mc_wdata, 8'h3C);
    chk("wr_mcrw", bus.mc_rw, 1);
    chk("wr_mcaddr", bus.mc_addr, 9);
    wait_rsp("wr", 1'b1, 8'h00, 1'b0);

    // FIFO full: blocker parked in RESP, then 4 accepted, 5th refused
    bus.rsp_ready = 1'b0;
    push(1'b0, 4'd1, 8'h00);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("full_blocker_rsp", bus.rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_pre", bus.cmd_ready, 1);
      push(1'b0, 4'(2 + i), 8'h00);
    end
    chk("full_count4", bus.fifo_count, 4);
    chk("full_ready0", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 4'd7;
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("full_refused_count", bus.fifo_count, 4);
    chk("full_still_resp", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    wait_rsp("full_r0", 1'b0, 8'h11, 1'b0);
    @(negedge clk);
    chk("full_count_after_pop", bus.fifo_count, 3);
    wait_rsp("full_r1", 1'b0, 8'h12, 1'b0);
    wait_rsp("full_r2", 1'b0, 8'h13, 1'b0);
    wait_rsp("full_r3", 1'b0, 8'h14, 1'b0);
    wait_rsp("full_r4", 1'b0, 8'h15, 1'b0);
    repeat (6) @(negedge clk);
    chk("full_no_extra", bus.busy, 0);

    // Timeout: controller never answers
    ctrl_dead = 1'b1;
    push(1'b0, 4'd3, 8'h00);
    cs_n = 0; n = 0;
    while (!bus.rsp_valid && n < 60) begin
      if (bus.mc_cs) cs_n++;
      @(negedge clk);
      n++;
    end
    chk("tmo_req_cycles", cs_n, 15);
    chk("tmo_seen", bus.rsp_valid, 1);
    chk("tmo_err", bus.rsp_err, 1);
    chk("tmo_rdata", bus.rsp_rdata, 0);
    chk("tmo_cs", bus.mc_cs, 0);
    ctrl_dead = 1'b0;
    @(negedge clk);
    push(1'b0, 4'd5, 8'h00);
    wait_rsp("after_tmo", 1'b0, 8'h15, 1'b0);

    // Back-to-back reads of addr 0 and 15
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 4'd0;
    @(negedge clk); bus.cmd_addr = 4'd15;
    @(negedge clk); bus.cmd_valid = 1'b0;
    chk("b2b_pushpop_count", bus.fifo_count, 1);
    for (int i = 0; i < 12; i++) begin
      cs_hist[i] = bus.mc_cs;
      if (bus.rsp_valid) rq.push_back(bus.rsp_rdata);
      @(negedge clk);
    end
    gap = 0; seen_hi = 0; in_gap = 0; done = 0;
    for (int i = 0; i < 12; i++) begin
      if (cs_hist[i]) begin
        if (in_gap) done = 1;
        seen_hi = 1;
      end else if (seen_hi && !done) begin
        in_gap = 1;
        gap++;
      end
    end
    chk("b2b_gap", gap, 2);
    chk("b2b_nrsp", rq.size(), 2);
    chk("b2b_rsp0", (rq.size() > 0) ? 32'(rq[0]) : 32'hDEAD, 8'h5A);
    chk("b2b_rsp1", (rq.size() > 1) ? 32'(rq[1]) : 32'hDEAD, 8'hC3);

    // Async reset during second REQ cycle
    push(1'b0, 4'd2, 8'h00);
    push(1'b0, 4'd4, 8'h00);
    chk("arst_cs_req1", bus.mc_cs, 1);
    @(negedge clk);
    chk("arst_cs_req2", bus.mc_cs, 1);
    chk("arst_count_pre", bus.fifo_count, 1);
    rst = 1'b1;
    #1;
    chk("arst_cs", bus.mc_cs, 0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_ready", bus.cmd_ready, 1);
    chk("arst_rspv", bus.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    any_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) any_rsp = 1;
      @(negedge clk);
    end
    chk("arst_no_rsp", any_rsp, 0);
    chk("arst_busy", bus.busy, 0);
    push(1'b0, 4'd5, 8'h00);
    wait_rsp("after_arst", 1'b0, 8'h15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_master.md
Name: mem_req_master

Overview:
- Initiator side of the memory-controller request interface.
- Accepts read/write commands from an upstream client into an N-deep FIFO.
- Issues each command as a cs/req/rw/addr/valid transaction to the memory controller and waits for its ready.
- Returns one response per command, carrying read data or a timeout error.

Parameters:
- R, 4: memory rows; row address width is clog2(R).
- C, 4: memory columns; column address width is clog2(C).
- N, 4: command FIFO depth; must be a power of 2, N >= 2.
- DW, 8: data width.
- TMO, 15: maximum REQ-state cycles without mc_ready before a timeout error is raised; must be >= 2.
- Derived: AW = clog2(R*C), addr = {row, col}.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_rw  in  1  1 = write, 0 = read
- cmd_addr  in  AW  target address
- cmd_wdata  in  DW  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  upstream accepts response
- rsp_rw  out  1  rw of the completed command
- rsp_rdata  out  DW  read data; 0 for writes and errors
- rsp_err  out  1  timeout occurred
- mc_cs  out  1  controller chip select
- mc_req  out  1  request strobe
- mc_rw  out  1  1 = write, 0 = read
- mc_addr  out  AW  address to controller
- mc_valid  out  1  write data valid (writes only)
- mc_wdata  out  DW  write data
- mc_ready  in  1  controller ready (registered in the controller)
- mc_rdata  in  DW  read data, valid while mc_ready = 1 on a read
- busy  out  1  state != IDLE or FIFO not empty
- fifo_count  out  clog2(N)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0 except cmd_ready, which is 1. FIFO is flushed, state goes to IDLE, timeout counter is cleared. Reset mid-transaction drops the in-flight command with no response and deasserts mc_cs immediately.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - Pop only by the FSM in IDLE.
  - cmd_ready depends only on !full; a push is refused when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full keeps the count unchanged.
  - Read and write pointers wrap modulo N.
- FSM states: IDLE, REQ, RESP.
  - IDLE: all mc_* outputs 0. If FIFO is non-empty, pop the head into holding registers and go to REQ next cycle.
  - REQ:
    - mc_cs = 1, mc_req = 1, mc_rw / mc_addr / mc_wdata from the holding registers, mc_valid = hold_rw. All are held stable for the whole state.
    - The timeout counter starts at 0 on entry and increments each cycle.
    - mc_ready is ignored in the first REQ cycle (it may be stale) and sampled from the second cycle on.
    - On mc_ready = 1: capture mc_rdata (reads) or 0 (writes), set err = 0, go to RESP.
    - If the counter reaches TMO - 1 without mc_ready: rdata = 0, err = 1, go to RESP.
  - RESP: mc_* outputs 0; rsp_valid = 1 and rsp_* are held stable. On rsp_ready, go to IDLE.
- Back-to-back commands always leave at least 2 cycles with mc_cs = 0 (RESP + IDLE). This guarantees the controller's ready has cleared before the next REQ.
- Latency with an idle FIFO and rsp_ready = 1:
  - cmd accepted at t.
  - IDLE pop at t+1.
  - REQ (mc_cs = 1) at t+2.
  - mc_ready sampled at t+3.
  - rsp_valid at t+4; IDLE at t+5.
- rsp_ready held low: FSM stays in RESP; the FIFO keeps accepting commands until full.
- No combinational path from any input to any mc_* output or to cmd_ready.

Decomposition:
- Package mem_req_pkg holds:
  - state enum {IDLE, REQ, RESP}
  - cmd struct {rw, addr, wdata}
  - RW_READ = 0 and RW_WRITE = 1 constants
- Sub-module sync_fifo (parameterised width and depth, outputs full / empty / count) instantiated once for commands.
- The FSM, holding registers and timeout counter live in the top.

Test Plan:
- Single read: push rw=0, addr=4'b0110; controller model returns rdata=8'hA5 -> mc_cs=1 with mc_addr=6 from t+2, row=1, col=2; rsp_valid at t+4 with rdata=A5, err=0.
- Single write: push rw=1, addr=9, wdata=8'h3C -> mc_valid=1, mc_wdata=3C during REQ; rsp_valid with rw=1, rdata=0, err=0.
- FIFO full: hold rsp_ready=0 and push 5 commands -> 4 accepted, cmd_ready=0 from the 5th, fifo_count=3 after the first pop; release rsp_ready -> 4 responses in order.
- Timeout: controller model never asserts ready -> REQ lasts exactly 15 cycles, then rsp_err=1, rdata=0, mc_cs drops; the next command proceeds normally.
- Back-to-back reads to addr 0 then addr 15 -> mc_cs low for exactly 2 cycles between them; responses in order with the correct data.
- Async reset asserted in the second REQ cycle -> mc_cs=0 immediately, fifo_count=0, no response; the next pushed command completes normally.
